// File: rtl/victim_swap_ctrl.sv
// Miss-path sequencer for the L1 D-cache and its 4-entry FIFO victim cache.
// It probes the victim cache, writes the L1 eviction into it, and fetches from memory only on a victim miss.
module victim_swap_ctrl #(
    parameter int LINE_W    = 128,
    parameter int TAG_W     = 20,
    parameter int V_ENTRIES = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [TAG_W-1:0]  miss_tag,
    input  logic              evict_valid,
    input  logic [TAG_W-1:0]  evict_tag,
    input  logic [LINE_W-1:0] evict_data,
    output logic              miss_ack,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [LINE_W-1:0] fill_data,
    output logic              fill_src_vc,
    output logic [TAG_W-1:0]  v_tag,
    output logic              v_wr_en,
    output logic [LINE_W-1:0] v_wdata,
    input  logic              v_hit,
    input  logic [LINE_W-1:0] v_rdata,
    output logic              mem_req,
    output logic [TAG_W-1:0]  mem_tag,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int WC_W = $clog2(V_ENTRIES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        EVICT    = 3'd2,
        MEM_REQ  = 3'd3,
        MEM_WAIT = 3'd4,
        FILL     = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TAG_W-1:0]  miss_tag_q;
    logic [TAG_W-1:0]  evict_tag_q;
    logic              evict_valid_q;
    logic [LINE_W-1:0] evict_data_q;
    logic [LINE_W-1:0] line_q;
    logic              hit_q;
    logic [WC_W-1:0]   wr_cnt;
    logic              qual_hit;
    logic              mem_data_take;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [WC_W-1:0] sat_inc_wr(input logic [WC_W-1:0] c);
        return (c == WC_W'(V_ENTRIES)) ? c : c + WC_W'(1);
    endfunction

    // Entries come out of reset holding tag 0, so a tag-0 match only counts once the FIFO has been fully written.
    assign qual_hit = v_hit & ((miss_tag_q != '0) | (wr_cnt == WC_W'(V_ENTRIES)));

    assign mem_data_take = mem_rvalid & (((state == MEM_REQ) & mem_gnt) | (state == MEM_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (miss_req) state_nxt = LOOKUP;
            LOOKUP: begin
                if (evict_valid_q)  state_nxt = EVICT;
                else if (qual_hit)  state_nxt = FILL;
                else                state_nxt = MEM_REQ;
            end
            EVICT:    state_nxt = hit_q ? FILL : MEM_REQ;
            MEM_REQ:  if (mem_gnt) state_nxt = mem_rvalid ? FILL : MEM_WAIT;
            MEM_WAIT: if (mem_rvalid) state_nxt = FILL;
            FILL:     if (fill_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_tag_q    <= '0;
            evict_tag_q   <= '0;
            evict_valid_q <= 1'b0;
            evict_data_q  <= '0;
            line_q        <= '0;
            hit_q         <= 1'b0;
            wr_cnt        <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            if ((state == IDLE) && miss_req) begin
                miss_tag_q    <= miss_tag;
                evict_valid_q <= evict_valid;
                evict_tag_q   <= evict_tag;
                evict_data_q  <= evict_data;
            end
            if (state == LOOKUP) begin
                hit_q  <= qual_hit;
                line_q <= v_rdata;
                if (qual_hit) hit_cnt  <= sat_inc_cnt(hit_cnt);
                else          miss_cnt <= sat_inc_cnt(miss_cnt);
            end
            if (state == EVICT) begin
                wr_cnt <= sat_inc_wr(wr_cnt);
            end
            if (mem_data_take) begin
                line_q <= mem_data_take ? mem_rdata : line_q;
            end
        end
    end

    // Every output is a pure decode of the state, so an asynchronous reset forces them all low immediately.
    always_comb begin
        miss_ack    = 1'b0;
        fill_valid  = 1'b0;
        fill_data   = '0;
        fill_src_vc = 1'b0;
        v_tag       = '0;
        v_wr_en     = 1'b0;
        v_wdata     = '0;
        mem_req     = 1'b0;
        mem_tag     = '0;
        case (state)
            LOOKUP: begin
                miss_ack = 1'b1;
                v_tag    = miss_tag_q;
            end
            EVICT: begin
                v_tag   = evict_tag_q;
                v_wr_en = 1'b1;
                v_wdata = evict_data_q;
            end
            MEM_REQ: begin
                mem_req = 1'b1;
                mem_tag = miss_tag_q;
            end
            FILL: begin
                fill_valid  = 1'b1;
                fill_data   = line_q;
                fill_src_vc = hit_q;
            end
            default: ;
        endcase
    end

endmodule
